// File: rtl/uart_rx_pkt_ctrl_if.sv
// Byte-strobe side and packet-consumer side of the UART receive packet controller.
// The controller takes the slave modport; the feeding/consuming logic takes master.
interface uart_rx_pkt_ctrl_if #(
    parameter int ADDR_W = 4
);
    logic              baud_x16_en;
    logic [7:0]        rx_data;
    logic              rx_data_rdy;
    logic              parity_err;
    logic              frm_err;
    logic [ADDR_W-1:0] pkt_rd_addr;
    logic [7:0]        pkt_rd_data;
    logic [4:0]        pkt_len;
    logic              pkt_valid;
    logic              pkt_ack;
    logic              err_pulse;
    logic [2:0]        err_code;
    logic              busy;

    modport slave (
        input  baud_x16_en, rx_data, rx_data_rdy, parity_err, frm_err,
        input  pkt_rd_addr, pkt_ack,
        output pkt_rd_data, pkt_len, pkt_valid, err_pulse, err_code, busy
    );

    modport master (
        output baud_x16_en, rx_data, rx_data_rdy, parity_err, frm_err,
        output pkt_rd_addr, pkt_ack,
        input  pkt_rd_data, pkt_len, pkt_valid, err_pulse, err_code, busy
    );
endinterface

// File: rtl/uart_rx_pkt_ctrl.sv
// Frames UART bytes into SOF/LEN/payload/CHK packets, buffers the payload and reports errors.
// PKT_VALID and ERR_PULSE one cycle after the deciding strobe; a held packet blocks intake until PKT_ACK.
module uart_rx_pkt_ctrl #(
    parameter logic [7:0] SOF_BYTE      = 8'hA5,
    parameter int         MAX_LEN       = 16,
    parameter int         ADDR_W        = 4,
    parameter int         TIMEOUT_TICKS = 320
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    uart_rx_pkt_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_CHK,
        S_HOLD
    } state_t;

    localparam logic [2:0] E_NONE    = 3'd0;
    localparam logic [2:0] E_PARITY  = 3'd1;
    localparam logic [2:0] E_FRAME   = 3'd2;
    localparam logic [2:0] E_LENGTH  = 3'd3;
    localparam logic [2:0] E_CSUM    = 3'd4;
    localparam logic [2:0] E_TIMEOUT = 3'd5;
    localparam logic [2:0] E_OVERRUN = 3'd6;

    state_t            r_state;
    logic [ADDR_W-1:0] r_idx;
    logic [7:0]        r_csum;
    logic [15:0]       r_tmo_cnt;
    logic              r_frm_q;
    logic [4:0]        r_pkt_len;
    logic              r_pkt_valid;
    logic              r_err_pulse;
    logic [2:0]        r_err_code;
    logic              r_busy;
    logic [7:0]        r_buf [2**ADDR_W];

    logic       w_acc;
    logic       w_sof;
    logic       w_frm_rise;
    logic       w_active;
    logic       w_tmo_hit;
    logic       w_len_bad;
    logic       w_last;
    logic [2:0] w_err_code;
    logic       w_err;
    logic       w_abort;
    logic       w_buf_we;

    assign w_acc      = bus.rx_data_rdy;
    assign w_sof      = w_acc && !bus.parity_err && (bus.rx_data == SOF_BYTE);
    assign w_frm_rise = bus.frm_err && !r_frm_q;
    assign w_active   = (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CHK);
    assign w_tmo_hit  = bus.baud_x16_en && ((r_tmo_cnt + 16'd1) == 16'(TIMEOUT_TICKS));
    assign w_len_bad  = bus.rx_data > 8'(MAX_LEN);
    assign w_last     = (5'(r_idx) + 5'd1) == r_pkt_len;

    // Error arbitration: parity > frame > length/checksum > timeout; a byte beats a timeout.
    always_comb begin
        w_err_code = E_NONE;
        if (r_state == S_HOLD) begin
            if (!bus.pkt_ack && w_acc)
                w_err_code = E_OVERRUN;
        end else if (w_active) begin
            if (w_acc && bus.parity_err)
                w_err_code = E_PARITY;
            else if (w_frm_rise)
                w_err_code = E_FRAME;
            else if (w_acc && (r_state == S_LEN) && w_len_bad)
                w_err_code = E_LENGTH;
            else if (w_acc && (r_state == S_CHK) && (bus.rx_data != r_csum))
                w_err_code = E_CSUM;
            else if (!w_acc && w_tmo_hit)
                w_err_code = E_TIMEOUT;
        end
    end

    assign w_err    = (w_err_code != E_NONE);
    assign w_abort  = w_err && w_active;
    assign w_buf_we = (r_state == S_PAYLOAD) && w_acc && !w_abort;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_csum      <= 8'd0;
            r_tmo_cnt   <= 16'd0;
            r_frm_q     <= 1'b0;
            r_pkt_len   <= 5'd0;
            r_pkt_valid <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_code  <= E_NONE;
            r_busy      <= 1'b0;
        end else begin
            r_frm_q     <= bus.frm_err;
            r_err_pulse <= w_err;
            if (w_err)
                r_err_code <= w_err_code;

            case (r_state)
                S_IDLE: begin
                    if (w_sof) begin
                        r_state   <= S_LEN;
                        r_busy    <= 1'b1;
                        r_tmo_cnt <= 16'd0;
                    end
                end

                S_HOLD: begin
                    if (bus.pkt_ack) begin
                        r_pkt_valid <= 1'b0;
                        // The strobe that arrives with the ACK is judged as if already idle.
                        if (w_sof) begin
                            r_state   <= S_LEN;
                            r_busy    <= 1'b1;
                            r_tmo_cnt <= 16'd0;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end

                S_LEN, S_PAYLOAD, S_CHK: begin
                    if (w_abort) begin
                        r_state   <= S_IDLE;
                        r_busy    <= 1'b0;
                        r_tmo_cnt <= 16'd0;
                    end else if (w_acc) begin
                        r_tmo_cnt <= 16'd0;
                        case (r_state)
                            S_LEN: begin
                                r_pkt_len <= bus.rx_data[4:0];
                                r_csum    <= bus.rx_data;
                                r_idx     <= '0;
                                r_state   <= (bus.rx_data == 8'd0) ? S_CHK : S_PAYLOAD;
                            end
                            S_PAYLOAD: begin
                                r_csum <= r_csum ^ bus.rx_data;
                                r_idx  <= r_idx + ADDR_W'(1);
                                if (w_last)
                                    r_state <= S_CHK;
                            end
                            default: begin
                                r_state     <= S_HOLD;
                                r_pkt_valid <= 1'b1;
                            end
                        endcase
                    end else if (bus.baud_x16_en) begin
                        r_tmo_cnt <= r_tmo_cnt + 16'd1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_buf_we)
            r_buf[r_idx] <= bus.rx_data;
    end

    assign bus.pkt_rd_data = r_buf[bus.pkt_rd_addr];
    assign bus.pkt_len     = r_pkt_len;
    assign bus.pkt_valid   = r_pkt_valid;
    assign bus.err_pulse   = r_err_pulse;
    assign bus.err_code    = r_err_code;
    assign bus.busy        = r_busy;

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Directed bench for uart_rx_pkt_ctrl: a frame-list model predicts every output each cycle.
module tb_uart_rx_pkt_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_rx_pkt_ctrl_if #(.ADDR_W(4)) bus ();

    uart_rx_pkt_ctrl #(
        .SOF_BYTE      (8'hA5),
        .MAX_LEN       (16),
        .ADDR_W        (4),
        .TIMEOUT_TICKS (320)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // Model: the bytes of the frame in progress, plus whether a packet is held.
    logic [7:0] m_frame [$];
    logic [7:0] m_buf [16];
    bit         m_held;
    int         m_len;
    int         m_code;
    bit         m_pulse;
    int         m_ticks;
    bit         m_frm_prev;

    function automatic void model_step();
        int         e;
        int         n;
        bit         rise;
        bit         sof;
        logic [7:0] x;
        e    = 0;
        rise = bus.frm_err && !m_frm_prev;
        m_frm_prev = bus.frm_err;
        sof  = bus.rx_data_rdy && !bus.parity_err && (bus.rx_data == 8'hA5);
        if (m_held) begin
            if (bus.pkt_ack) begin
                m_held = 1'b0;
                if (sof) begin
                    m_frame = {8'hA5};
                    m_ticks = 0;
                end
            end else if (bus.rx_data_rdy) begin
                e = 6;
            end
        end else if (m_frame.size() == 0) begin
            if (sof) begin
                m_frame = {8'hA5};
                m_ticks = 0;
            end
        end else begin
            if (bus.rx_data_rdy && bus.parity_err) e = 1;
            else if (rise) e = 2;
            else if (bus.rx_data_rdy) begin
                m_frame.push_back(bus.rx_data);
                m_ticks = 0;
                n = m_frame.size();
                if (n == 2) begin
                    if (bus.rx_data > 8'd16) e = 3;
                    else m_len = int'(bus.rx_data);
                end else if (n == 3 + m_len) begin
                    x = 8'd0;
                    for (int i = 1; i < n - 1; i++) x = x ^ m_frame[i];
                    if (x == bus.rx_data) begin
                        m_held = 1'b1;
                        m_frame.delete();
                    end else e = 4;
                end else begin
                    m_buf[n-3] = bus.rx_data;
                end
            end else if (bus.baud_x16_en) begin
                m_ticks++;
                if (m_ticks == 320) e = 5;
            end
            if (e != 0) m_frame.delete();
        end
        m_pulse = (e != 0);
        if (e != 0) m_code = e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_frame.delete();
            m_held = 1'b0; m_len = 0; m_code = 0; m_pulse = 1'b0;
            m_ticks = 0; m_frm_prev = 1'b0;
        end else begin
            model_step();
        end
    end

    always @(posedge clk) begin
        #2;
        check("pkt_valid", 32'(bus.pkt_valid), 32'(m_held));
        check("pkt_len",   32'(bus.pkt_len),   32'(m_len));
        check("err_pulse", 32'(bus.err_pulse), 32'(m_pulse));
        check("err_code",  32'(bus.err_code),  32'(m_code));
        check("busy",      32'(bus.busy),      32'(m_held || (m_frame.size() != 0)));
        if (m_held && (int'(bus.pkt_rd_addr) < m_len))
            check("rd_data", 32'(bus.pkt_rd_data), 32'(m_buf[bus.pkt_rd_addr]));
    end

    logic [7:0] pkt [$];

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input bit par, input bit tick);
        bus.rx_data     = b;
        bus.rx_data_rdy = 1'b1;
        bus.parity_err  = par;
        bus.baud_x16_en = tick;
        @(negedge clk);
        bus.rx_data_rdy = 1'b0;
        bus.parity_err  = 1'b0;
        bus.baud_x16_en = 1'b0;
    endtask

    task automatic send_pkt();
        foreach (pkt[i]) begin
            send(pkt[i], 1'b0, 1'b0);
            if (i != pkt.size() - 1) gap(1);
        end
    endtask

    task automatic ticks(input int n);
        bus.baud_x16_en = 1'b1;
        repeat (n) @(negedge clk);
        bus.baud_x16_en = 1'b0;
    endtask

    task automatic ack();
        bus.pkt_ack = 1'b1;
        @(negedge clk);
        bus.pkt_ack = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [7:0] exp, input string nm);
        bus.pkt_rd_addr = a;
        #1;
        check(nm, 32'(bus.pkt_rd_data), 32'(exp));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        bus.baud_x16_en = 1'b0; bus.rx_data = 8'd0; bus.rx_data_rdy = 1'b0;
        bus.parity_err = 1'b0;  bus.frm_err = 1'b0; bus.pkt_rd_addr = 4'd0;
        bus.pkt_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(bus.pkt_valid), 32'd0);
        check("rst_len",   32'(bus.pkt_len),   32'd0);
        check("rst_code",  32'(bus.err_code),  32'd0);
        check("rst_busy",  32'(bus.busy),      32'd0);
        rst_n = 1'b1;
        gap(2);

        // Good packet, read back, ACK
        pkt = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        send_pkt();
        check("t1_valid", 32'(bus.pkt_valid), 32'd1);
        check("t1_len",   32'(bus.pkt_len),   32'd3);
        rd(4'd0, 8'h11, "t1_rd0");
        rd(4'd1, 8'h22, "t1_rd1");
        rd(4'd2, 8'h33, "t1_rd2");
        gap(3);
        ack();
        check("t1_ack_valid", 32'(bus.pkt_valid), 32'd0);
        check("t1_ack_busy",  32'(bus.busy),      32'd0);
        gap(2);

        // Checksum error, then zero-length packet
        pkt = {8'hA5, 8'h02, 8'h10, 8'h20, 8'h31};
        send_pkt();
        check("t2_pulse", 32'(bus.err_pulse), 32'd1);
        check("t2_code",  32'(bus.err_code),  32'd4);
        gap(1);
        check("t2_pulse_off", 32'(bus.err_pulse), 32'd0);
        pkt = {8'hA5, 8'h00, 8'h00};
        send_pkt();
        check("t2_zero_valid", 32'(bus.pkt_valid), 32'd1);
        check("t2_zero_len",   32'(bus.pkt_len),   32'd0);
        ack();
        gap(2);

        // Oversize length, then stray bytes
        pkt = {8'hA5, 8'h11};
        send_pkt();
        check("t3_code", 32'(bus.err_code), 32'd3);
        check("t3_busy", 32'(bus.busy),     32'd0);
        gap(1);
        pkt = {8'h55, 8'h66};
        send_pkt();
        gap(1);
        check("t3_stray_busy", 32'(bus.busy), 32'd0);

        // Timeout boundary: 320 ticks fires, 319 plus a byte does not
        pkt = {8'hA5, 8'h02, 8'hAA};
        send_pkt();
        ticks(319);
        check("t4_319_busy", 32'(bus.busy), 32'd1);
        ticks(1);
        check("t4_320_pulse", 32'(bus.err_pulse), 32'd1);
        check("t4_320_code",  32'(bus.err_code),  32'd5);
        gap(2);
        send_pkt();
        ticks(319);
        send(8'hBB, 1'b0, 1'b1);
        check("t4_race_pulse", 32'(bus.err_pulse), 32'd0);
        gap(1);
        send(8'h13, 1'b0, 1'b0);
        check("t4_valid", 32'(bus.pkt_valid), 32'd1);
        check("t4_len",   32'(bus.pkt_len),   32'd2);

        // Overrun while held, then ACK together with SOF
        gap(2);
        send(8'h77, 1'b0, 1'b0);
        check("t5_code",  32'(bus.err_code),  32'd6);
        check("t5_valid", 32'(bus.pkt_valid), 32'd1);
        rd(4'd0, 8'hAA, "t5_rd0");
        rd(4'd1, 8'hBB, "t5_rd1");
        gap(1);
        bus.pkt_ack = 1'b1;
        send(8'hA5, 1'b0, 1'b0);
        bus.pkt_ack = 1'b0;
        check("t5_acksof_valid", 32'(bus.pkt_valid), 32'd0);
        check("t5_acksof_busy",  32'(bus.busy),      32'd1);
        gap(1);
        pkt = {8'h01, 8'h5A, 8'h5B};
        send_pkt();
        check("t5_len1", 32'(bus.pkt_len), 32'd1);
        rd(4'd0, 8'h5A, "t5_rd_new");
        ack();
        gap(2);

        // Parity, framing, async reset mid-packet
        pkt = {8'hA5, 8'h03, 8'h11};
        send_pkt();
        gap(1);
        send(8'h22, 1'b1, 1'b0);
        check("t6_par_code", 32'(bus.err_code), 32'd1);
        gap(2);
        send_pkt();
        gap(1);
        bus.frm_err = 1'b1;
        @(negedge clk);
        check("t6_frm_code", 32'(bus.err_code), 32'd2);
        check("t6_frm_busy", 32'(bus.busy),     32'd0);
        gap(2);
        bus.frm_err = 1'b0;
        gap(2);
        send_pkt();
        gap(1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy",  32'(bus.busy),      32'd0);
        check("t6_rst_len",   32'(bus.pkt_len),   32'd0);
        check("t6_rst_code",  32'(bus.err_code),  32'd0);
        check("t6_rst_pulse", 32'(bus.err_pulse), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        gap(3);
        check("t6_post_pulse", 32'(bus.err_pulse), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
